// File: rtl/nios2_c_sd_spi_ctrl.sv
// rtl/nios2_c_sd_spi_ctrl.sv - Avalon-MM SD-card SPI byte engine with programmable SD_CLK divider
//
// Optional feature macro: SD_SPI_IRQ_EN (adds irq output and CTRL bit3 irq_en).
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   chipselect, address  Avalon slave select and register index (0 DATA, 1 CTRL, 2 DIVIDER)
//   write_n, read_n      Avalon strobes, active low
//   writedata, readdata  32-bit data; readdata is combinational (zero wait states)
//   sd_miso              card DO, already synchronised
//   sd_clk, sd_mosi      SPI mode-0 clock and card DI
//   sd_cs_n              card chip select, software controlled
//   irq                  done & irq_en (only with SD_SPI_IRQ_EN)
module nios2_c_sd_spi_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'h00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sd_miso,
  output logic        sd_clk,
  output logic        sd_mosi,
  output logic        sd_cs_n
`ifdef SD_SPI_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d;
  logic        irq_en_q;
  logic        busy;
  logic        done_set;

  logic wr, wr_data, wr_ctrl, wr_div, cnt_exp;

  assign wr      = chipselect && !write_n;
  assign wr_data = wr && (address == 2'd0);
  assign wr_ctrl = wr && (address == 2'd1);
  assign wr_div  = wr && (address == 2'd2);
  assign cnt_exp = (cnt_q == 16'd0);

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:16]};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      div_q     <= DIV_RESET;
      div_lat_q <= DIV_RESET;
      shreg_q   <= 8'd0;
      rx_q      <= 8'd0;
      bitcnt_q  <= 3'd0;
      mosi_q    <= 1'b1;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      bitcnt_q  <= bitcnt_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
    end
  end

`ifdef SD_SPI_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_q <= writedata[3];
    end
  end
  assign irq = done_q & irq_en_q;
`else
  assign irq_en_q = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    bitcnt_d  = bitcnt_q;
    mosi_d    = mosi_q;
    done_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_data) begin
          // Divider is latched here so DIVIDER writes only affect later bytes.
          state_d   = ST_LOW;
          cnt_d     = div_q;
          div_lat_d = div_q;
          shreg_d   = writedata[7:0];
          mosi_d    = writedata[7];
          bitcnt_d  = 3'd0;
        end
      end
      ST_LOW: begin
        if (cnt_exp) begin
          // Rising SD_CLK: sample MISO into the LSB; MSB now holds the next tx bit.
          state_d = ST_HIGH;
          cnt_d   = div_lat_q;
          shreg_d = {shreg_q[6:0], sd_miso};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_exp) begin
          cnt_d = div_lat_q;
          if (bitcnt_q == 3'd7) begin
            state_d  = ST_IDLE;
            rx_d     = shreg_q;
            mosi_d   = 1'b1;
            done_set = 1'b1;
          end else begin
            state_d  = ST_LOW;
            mosi_d   = shreg_q[7];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Software-owned registers; completion beats a coincident done-clear.
  always_comb begin
    div_d  = wr_div ? writedata[15:0] : div_q;
    cs_n_d = wr_ctrl ? writedata[1] : cs_n_q;
    done_d = done_q;
    if (done_set) begin
      done_d = 1'b1;
    end else if (wr_ctrl && writedata[2]) begin
      done_d = 1'b0;
    end
  end

  // FSM outputs
  always_comb begin
    sd_clk = (state_q == ST_HIGH);
    busy   = (state_q != ST_IDLE);
  end

  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

  always_comb begin
    readdata = 32'd0;
    if (chipselect && !read_n) begin
      case (address)
        2'd0:    readdata = {24'd0, rx_q};
        2'd1:    readdata = {28'd0, irq_en_q, done_q, cs_n_q, busy};
        2'd2:    readdata = {16'd0, div_q};
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_c_sd_spi_ctrl.sv
// tb/tb_nios2_c_sd_spi_ctrl.sv - directed self-checking bench for nios2_c_sd_spi_ctrl
module tb_nios2_c_sd_spi_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sd_miso;
  logic        sd_clk, sd_mosi, sd_cs_n;
  logic        loop_en = 1'b0;
  logic        miso_fix = 1'b0;
`ifdef SD_SPI_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign sd_miso = loop_en ? sd_mosi : miso_fix;

  always #5 clk = ~clk;

  nios2_c_sd_spi_ctrl #(.DIV_RESET(16'h00FF)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .sd_miso(sd_miso), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_cs_n(sd_cs_n)
`ifdef SD_SPI_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  // Samples once per clk on the falling edge until busy drops.
  task automatic watch(output int busy_cyc, output int pulses, output logic [7:0] bits,
                       output int first_high);
    logic prev;
    bit   timed_out;
    prev = 1'b0; busy_cyc = 0; pulses = 0; bits = 8'd0; first_high = 0; timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!dut.busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cyc++;
      if (sd_clk && !prev) begin
        pulses++;
        bits = {bits[6:0], sd_mosi};
      end
      if (sd_clk && pulses == 1) first_high++;
      prev = sd_clk;
    end
    if (timed_out) check("watch_timeout", 32'd1, 32'd0);
  endtask

  logic [31:0] rd;
  logic [7:0]  mb;
  int          bc, pc, fh;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0);
    bus_read(2'd1, rd); check("rst_ctrl", rd, 32'h2);
    bus_read(2'd2, rd); check("rst_div", rd, 32'h00FF);
    bus_read(2'd3, rd); check("rst_addr3", rd, 32'h0);
    check("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    check("rst_sdclk", {31'd0, sd_clk}, 32'd0);
    check("rst_mosi", {31'd0, sd_mosi}, 32'd1);

    // div=0, loopback, 0xA5
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'd0);
    check("cs_low", {31'd0, sd_cs_n}, 32'd0);
    loop_en = 1'b1;
    bus_write(2'd0, 32'hA5);
    watch(bc, pc, mb, fh);
    check("a5_busy", bc, 16);
    check("a5_pulses", pc, 8);
    check("a5_mosi", {24'd0, mb}, 32'hA5);
    check("a5_high", fh, 1);
    bus_read(2'd0, rd); check("a5_data", rd, 32'hA5);
    bus_read(2'd1, rd); check("a5_ctrl", rd, 32'h4);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd); check("clr_done", rd, 32'h0);

    // div=3, MISO=0, 0xFF
    bus_write(2'd2, 32'd3);
    bus_read(2'd2, rd); check("div3", rd, 32'h3);
    loop_en = 1'b0; miso_fix = 1'b0;
    bus_write(2'd0, 32'hFF);
    watch(bc, pc, mb, fh);
    check("ff_busy", bc, 64);
    check("ff_pulses", pc, 8);
    check("ff_mosi", {24'd0, mb}, 32'hFF);
    check("ff_high", fh, 4);
    bus_read(2'd0, rd); check("ff_data", rd, 32'h0);

    // Busy DATA write ignored, DIVIDER write deferred to next byte
    loop_en = 1'b1;
    bus_write(2'd0, 32'h34);
    fork
      watch(bc, pc, mb, fh);
      begin
        repeat (5) @(negedge clk);
        bus_write(2'd0, 32'h12);
        bus_write(2'd2, 32'd1);
      end
    join
    check("34_busy", bc, 64);
    check("34_pulses", pc, 8);
    check("34_mosi", {24'd0, mb}, 32'h34);
    check("34_high", fh, 4);
    bus_read(2'd0, rd); check("34_data", rd, 32'h34);
    bus_read(2'd2, rd); check("div1", rd, 32'h1);
    bus_write(2'd0, 32'h5A);
    watch(bc, pc, mb, fh);
    check("5a_busy", bc, 32);
    check("5a_high", fh, 2);
    check("5a_mosi", {24'd0, mb}, 32'h5A);
    bus_read(2'd0, rd); check("5a_data", rd, 32'h5A);

    // Reset 20 cycles into a div=3 transfer
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'hC3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_sdclk", {31'd0, sd_clk}, 32'd0);
    check("abort_mosi", {31'd0, sd_mosi}, 32'd1);
    bus_read(2'd1, rd); check("abort_ctrl", rd, 32'h2);
    bus_read(2'd0, rd); check("abort_data", rd, 32'h0);
    reset = 1'b0;
    bus_read(2'd2, rd); check("abort_div", rd, 32'h00FF);

    // Done-clear coinciding with completion: completion wins
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h96);
    repeat (15) @(negedge clk);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd); check("clr_vs_done", rd, 32'h4);

    // DATA write on the completion edge is ignored
    bus_write(2'd1, 32'h4);
    bus_write(2'd0, 32'h11);
    repeat (15) @(negedge clk);
    bus_write(2'd0, 32'h77);
    bus_read(2'd1, rd); check("late_wr_ctrl", rd, 32'h4);
    bus_read(2'd0, rd); check("late_wr_data", rd, 32'h11);

`ifdef SD_SPI_IRQ_EN
    bus_write(2'd1, 32'hC);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, rd); check("irq_en_rd", rd, 32'h8);
    check("irq_idle", {31'd0, irq}, 32'd0);
    bus_write(2'd0, 32'h3C);
    watch(bc, pc, mb, fh);
    check("irq_rise", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'hC);
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
